// File: rtl/fround_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fround_pkg
//  Description : Shared definitions for the fround/froundnx issue stage:
//                format encodings, per-format field geometry, rounding-mode
//                encodings and the unpacked-operand record.
//  Revision    : 1.0 - initial release
// ============================================================================
package fround_pkg;

    // Format field encodings
    localparam logic [1:0] FMT_S = 2'b00;
    localparam logic [1:0] FMT_D = 2'b01;
    localparam logic [1:0] FMT_H = 2'b10;
    localparam logic [1:0] FMT_Q = 2'b11;

    // Widest supported format (double) sets the unpacked field widths
    localparam int NE_W = 11;
    localparam int NF_W = 52;

    // Per-format exponent width, fraction width and bias
    localparam int S_NE   = 8;
    localparam int S_NF   = 23;
    localparam int S_BIAS = 127;
    localparam int D_NE   = 11;
    localparam int D_NF   = 52;
    localparam int D_BIAS = 1023;
    localparam int H_NE   = 5;
    localparam int H_NF   = 10;
    localparam int H_BIAS = 15;

    // Offset added to a normal narrow exponent to re-bias it to the wide bias
    localparam int S_OFFSET = D_BIAS - S_BIAS;  // 896
    localparam int H_OFFSET = D_BIAS - H_BIAS;  // 1008

    // Fraction-bit counts reported downstream
    localparam int NF_S = S_NF;
    localparam int NF_D = D_NF;
    localparam int NF_H = H_NF;

    // Rounding-mode encodings
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RZ  = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    // Operand after unpacking into the widest format's field layout
    typedef struct packed {
        logic              sign;
        logic [NE_W-1:0]   exp;
        logic [NF_W:0]     sig;   // U1.NF, hidden bit in the MSB
        logic              nan;
        logic              snan;
    } unpacked_t;

endpackage
`default_nettype wire

// File: rtl/fround_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fround_unpack
//  Description : Combinational operand unpacker. Splits a NaN-boxed packed
//                operand into sign, exponent re-biased to the wide bias,
//                left-aligned U1.NF significand and NaN classification.
//  Ports       : X   (in)  packed operand, narrow formats NaN-boxed
//                Fmt (in)  format select
//                u   (out) unpacked operand record
//  Revision    : 1.0 - initial release
// ============================================================================
module fround_unpack
    import fround_pkg::*;
#(
    parameter int FLEN = 64,
    parameter int BIAS = 1023
) (
    input  logic [FLEN-1:0] X,
    input  logic [1:0]      Fmt,
    output unpacked_t       u
);

    localparam int c_S_OFF = BIAS - S_BIAS;
    localparam int c_H_OFF = BIAS - H_BIAS;

    logic              w_sbox;
    logic              w_hbox;
    logic [S_NE-1:0]   w_se;
    logic [S_NF-1:0]   w_sf;
    logic [H_NE-1:0]   w_he;
    logic [H_NF-1:0]   w_hf;
    logic [D_NE-1:0]   w_de;
    logic [D_NF-1:0]   w_df;

    assign w_sbox = &X[63:32];
    assign w_hbox = &X[63:16];
    assign w_se   = X[30:23];
    assign w_sf   = X[22:0];
    assign w_he   = X[14:10];
    assign w_hf   = X[9:0];
    assign w_de   = X[62:52];
    assign w_df   = X[51:0];

    always_comb begin
        u = '0;
        case (Fmt)
            FMT_D: begin
                u.sign = X[63];
                u.exp  = w_de;
                u.sig  = {(|w_de), w_df};
                u.nan  = (&w_de) & (|w_df);
                u.snan = (&w_de) & (|w_df) & ~w_df[D_NF-1];
            end
            FMT_S: begin
                if (!w_sbox) begin
                    // Improperly boxed value reads as the canonical quiet NaN
                    u.sign = 1'b0;
                    u.exp  = '1;
                    u.sig  = {2'b11, {(NF_W-1){1'b0}}};
                    u.nan  = 1'b1;
                    u.snan = 1'b0;
                end else begin
                    u.sign = X[31];
                    if (w_se == '0)
                        u.exp = '0;
                    else if (&w_se)
                        u.exp = '1;
                    else
                        u.exp = NE_W'(w_se) + NE_W'(c_S_OFF);
                    u.sig  = {(|w_se), w_sf, {(NF_W-S_NF){1'b0}}};
                    u.nan  = (&w_se) & (|w_sf);
                    u.snan = (&w_se) & (|w_sf) & ~w_sf[S_NF-1];
                end
            end
            FMT_H: begin
                if (!w_hbox) begin
                    u.sign = 1'b0;
                    u.exp  = '1;
                    u.sig  = {2'b11, {(NF_W-1){1'b0}}};
                    u.nan  = 1'b1;
                    u.snan = 1'b0;
                end else begin
                    u.sign = X[15];
                    if (w_he == '0)
                        u.exp = '0;
                    else if (&w_he)
                        u.exp = '1;
                    else
                        u.exp = NE_W'(w_he) + NE_W'(c_H_OFF);
                    u.sig  = {(|w_he), w_hf, {(NF_W-H_NF){1'b0}}};
                    u.nan  = (&w_he) & (|w_hf);
                    u.snan = (&w_he) & (|w_hf) & ~w_hf[H_NF-1];
                end
            end
            default: u = '0;  // quad is never enqueued
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fround_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fround_issue
//  Description : Issue/operand stage for the round-to-integer datapath.
//                Accepts packed operands, resolves the rounding mode,
//                rejects illegal requests, unpacks operands and holds up to
//                two requests in a skid buffer whose head drives the outputs.
//  Ports       : clk, reset_n         clock, async active-low reset
//                FlushE               synchronous flush of buffered requests
//                InValid/InReady      request handshake
//                X, FmtIn, InstrFrm, CsrFrm, NXEnIn   request payload
//                OutValid/OutReady    head handshake
//                Xs, Xe, Xm, XNaN, XSNaN, Fmt, Frm, Nf, ZfaFRoundNX  head
//                IllegalOp            pulse for a rejected request
//  Revision    : 1.0 - initial release
// ============================================================================
module fround_issue
    import fround_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int NE      = 11,
    parameter int NF      = 52,
    parameter int BIAS    = 1023,
    parameter int FMTBITS = 2,
    parameter int LOGFLEN = 6,
    parameter int HAS_H   = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               FlushE,
    input  logic               InValid,
    output logic               InReady,
    input  logic [FLEN-1:0]    X,
    input  logic [FMTBITS-1:0] FmtIn,
    input  logic [2:0]         InstrFrm,
    input  logic [2:0]         CsrFrm,
    input  logic               NXEnIn,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               Xs,
    output logic [NE-1:0]      Xe,
    output logic [NF:0]        Xm,
    output logic               XNaN,
    output logic               XSNaN,
    output logic [FMTBITS-1:0] Fmt,
    output logic [2:0]         Frm,
    output logic [LOGFLEN-1:0] Nf,
    output logic               ZfaFRoundNX,
    output logic               IllegalOp
);

    // Buffer state
    logic [1:0]          r_count;
    logic                r_rd;
    logic                r_wr;
    logic                r_illegal;
    unpacked_t           r_op  [2];
    logic [FMTBITS-1:0]  r_fmt [2];
    logic [2:0]          r_frm [2];
    logic [LOGFLEN-1:0]  r_nf  [2];
    logic                r_nx  [2];

    logic [2:0]          w_rm;
    logic                w_illegal;
    logic                w_accept;
    logic                w_enq;
    logic                w_deq;
    logic [LOGFLEN-1:0]  w_nf;
    unpacked_t           w_unp;

    fround_unpack #(
        .FLEN (FLEN),
        .BIAS (BIAS)
    ) u_unpack (
        .X   (X),
        .Fmt (FmtIn[1:0]),
        .u   (w_unp)
    );

    assign w_rm = (InstrFrm == DYN) ? CsrFrm : InstrFrm;

    // rm 101..111 are reserved; quad never legal; half only when built in
    assign w_illegal = (w_rm[2] & (w_rm[1] | w_rm[0]))
                     | (FmtIn == FMT_Q)
                     | ((FmtIn == FMT_H) && (HAS_H == 0));

    // Ready depends only on the registered occupancy
    assign InReady  = (r_count != 2'd2);
    assign OutValid = (r_count != 2'd0);

    assign w_accept = InValid & InReady;
    assign w_enq    = w_accept & ~w_illegal & ~FlushE;
    assign w_deq    = OutValid & OutReady;

    always_comb begin
        w_nf = '0;
        case (FmtIn)
            FMT_S:   w_nf = LOGFLEN'(NF_S);
            FMT_D:   w_nf = LOGFLEN'(NF_D);
            FMT_H:   w_nf = LOGFLEN'(NF_H);
            default: w_nf = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= 2'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_op[i]  <= '0;
                r_fmt[i] <= '0;
                r_frm[i] <= '0;
                r_nf[i]  <= '0;
                r_nx[i]  <= 1'b0;
            end
        end else begin
            r_illegal <= w_accept & w_illegal & ~FlushE;
            if (FlushE) begin
                r_count <= 2'd0;
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_op[r_wr]  <= w_unp;
                    r_fmt[r_wr] <= FmtIn;
                    r_frm[r_wr] <= w_rm;
                    r_nf[r_wr]  <= w_nf;
                    r_nx[r_wr]  <= NXEnIn;
                    r_wr        <= ~r_wr;
                end
                if (w_deq)
                    r_rd <= ~r_rd;
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign Xs          = r_op[r_rd].sign;
    assign Xe          = r_op[r_rd].exp;
    assign Xm          = r_op[r_rd].sig;
    assign XNaN        = r_op[r_rd].nan;
    assign XSNaN       = r_op[r_rd].snan;
    assign Fmt         = r_fmt[r_rd];
    assign Frm         = r_frm[r_rd];
    assign Nf          = r_nf[r_rd];
    assign ZfaFRoundNX = r_nx[r_rd];
    assign IllegalOp   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_fround_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fround_issue
//  Description : Self-checking bench for fround_issue: directed scenarios
//                plus randomized traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fround_issue;

    typedef struct packed {
        logic        s;
        logic [10:0] e;
        logic [52:0] m;
        logic        nan;
        logic        snan;
        logic [1:0]  fmt;
        logic [2:0]  frm;
        logic [5:0]  nf;
        logic        nx;
    } item_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        FlushE;
    logic        InValid;
    logic        InReady;
    logic [63:0] X;
    logic [1:0]  FmtIn;
    logic [2:0]  InstrFrm;
    logic [2:0]  CsrFrm;
    logic        NXEnIn;
    logic        OutValid;
    logic        OutReady;
    logic        Xs;
    logic [10:0] Xe;
    logic [52:0] Xm;
    logic        XNaN;
    logic        XSNaN;
    logic [1:0]  Fmt;
    logic [2:0]  Frm;
    logic [5:0]  Nf;
    logic        ZfaFRoundNX;
    logic        IllegalOp;
    logic [78:0] head;

    int total = 0;
    int bad   = 0;

    assign head = {Xs, Xe, Xm, XNaN, XSNaN, Fmt, Frm, Nf, ZfaFRoundNX};

    fround_issue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .FlushE      (FlushE),
        .InValid     (InValid),
        .InReady     (InReady),
        .X           (X),
        .FmtIn       (FmtIn),
        .InstrFrm    (InstrFrm),
        .CsrFrm      (CsrFrm),
        .NXEnIn      (NXEnIn),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .Xs          (Xs),
        .Xe          (Xe),
        .Xm          (Xm),
        .XNaN        (XNaN),
        .XSNaN       (XSNaN),
        .Fmt         (Fmt),
        .Frm         (Frm),
        .Nf          (Nf),
        .ZfaFRoundNX (ZfaFRoundNX),
        .IllegalOp   (IllegalOp)
    );

    always #5 clk = ~clk;

    // Reference: field values derived directly from the IEEE encodings
    function automatic item_t model(input logic [63:0] x, input logic [1:0] f,
                                    input logic [2:0] rm, input logic nx);
        item_t r;
        int    ev;
        r     = '0;
        r.fmt = f;
        r.frm = rm;
        r.nx  = nx;
        if (f == 2'b01) begin
            r.nf   = 6'd52;
            r.s    = x[63];
            r.e    = x[62:52];
            r.m    = {(x[62:52] != 0), x[51:0]};
            r.nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 0);
            r.snan = r.nan && !x[51];
        end else begin
            r.nf = 6'd23;
            if (x[63:32] != 32'hFFFF_FFFF) begin
                r.e   = 11'h7FF;
                r.m   = 53'h18000000000000;
                r.nan = 1'b1;
            end else begin
                r.s = x[31];
                ev  = int'(x[30:23]);
                if (ev == 0)        r.e = 11'd0;
                else if (ev == 255) r.e = 11'h7FF;
                else                r.e = 11'(ev - 127 + 1023);
                r.m    = ({52'd0, (ev != 0)} << 52) | ({30'd0, x[22:0]} << 29);
                r.nan  = (ev == 255) && (x[22:0] != 0);
                r.snan = r.nan && !x[22];
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] x, input logic [1:0] f,
                         input logic [2:0] ifr, input logic [2:0] cfr, input logic nx);
        X = x; FmtIn = f; InstrFrm = ifr; CsrFrm = cfr; NXEnIn = nx;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; FlushE = 1'b0; InValid = 1'b0; X = '0; FmtIn = '0;
        InstrFrm = '0; CsrFrm = '0; NXEnIn = 1'b0; OutReady = 1'b0;
        #22;
        total++;
        if ({OutValid, InReady, IllegalOp} !== 3'b010) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 010", {OutValid, InReady, IllegalOp});
        end
        total++;
        if (head !== 79'd0) begin
            bad++;
            $display("FAIL reset_payload: got %h want 0", head);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_double();
        OutReady = 1'b1;
        issue(64'h4004000000000000, 2'b01, 3'b000, 3'b000, 1'b0);
        total++;
        if (OutValid !== 1'b1) begin
            bad++;
            $display("FAIL double_valid: got %b want 1", OutValid);
        end
        total++;
        if (head !== {1'b0, 11'h400, 53'h14000000000000, 2'b00, 2'b01, 3'b000, 6'd52, 1'b0}) begin
            bad++;
            $display("FAIL double_head: got %h", head);
        end
        tick();
        total++;
        if (OutValid !== 1'b0) begin
            bad++;
            $display("FAIL double_drain: got %b want 0", OutValid);
        end
    endtask

    task automatic test_single();
        OutReady = 1'b1;
        issue(64'hFFFFFFFFBFC00000, 2'b00, 3'b111, 3'b011, 1'b1);
        total++;
        if (head !== {1'b1, 11'h3FF, 53'h18000000000000, 2'b00, 2'b00, 3'b011, 6'd23, 1'b1}) begin
            bad++;
            $display("FAIL single_boxed: got %h", head);
        end
        tick();
        issue(64'h00000000BFC00000, 2'b00, 3'b001, 3'b000, 1'b0);
        total++;
        if (head !== {1'b0, 11'h7FF, 53'h18000000000000, 2'b10, 2'b00, 3'b001, 6'd23, 1'b0}) begin
            bad++;
            $display("FAIL single_unboxed: got %h", head);
        end
        tick();
    endtask

    task automatic test_nan();
        OutReady = 1'b1;
        issue(64'hFFFFFFFF7F800001, 2'b00, 3'b000, 3'b000, 1'b0);
        total++;
        if ({OutValid, Xe, Xm, XNaN, XSNaN} !== {1'b1, 11'h7FF, 53'h10000020000000, 2'b11}) begin
            bad++;
            $display("FAIL snan: got %b %h %h %b%b", OutValid, Xe, Xm, XNaN, XSNaN);
        end
        tick();
        issue(64'hFFFFFFFF7FC00000, 2'b00, 3'b000, 3'b000, 1'b0);
        total++;
        if ({OutValid, XNaN, XSNaN} !== 3'b110) begin
            bad++;
            $display("FAIL qnan: got %b want 110", {OutValid, XNaN, XSNaN});
        end
        tick();
    endtask

    task automatic test_illegal();
        OutReady = 1'b1;
        issue(64'h4004000000000000, 2'b01, 3'b111, 3'b101, 1'b0);
        total++;
        if ({IllegalOp, OutValid, InReady} !== 3'b101) begin
            bad++;
            $display("FAIL illegal_rm: got %b want 101", {IllegalOp, OutValid, InReady});
        end
        tick();
        total++;
        if ({IllegalOp, OutValid} !== 2'b00) begin
            bad++;
            $display("FAIL illegal_pulse: got %b want 00", {IllegalOp, OutValid});
        end
        issue(64'h4004000000000000, 2'b11, 3'b000, 3'b000, 1'b0);
        total++;
        if ({IllegalOp, OutValid, InReady} !== 3'b101) begin
            bad++;
            $display("FAIL illegal_quad: got %b want 101", {IllegalOp, OutValid, InReady});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        item_t a, b, c;
        a = model(64'h3FF0000000000000, 2'b01, 3'b000, 1'b0);
        b = model(64'h4000000000000000, 2'b01, 3'b001, 1'b1);
        c = model(64'hC008000000000000, 2'b01, 3'b100, 1'b0);
        OutReady = 1'b0;
        FmtIn = 2'b01; CsrFrm = 3'b000; InValid = 1'b1;
        X = 64'h3FF0000000000000; InstrFrm = 3'b000; NXEnIn = 1'b0;
        tick();
        X = 64'h4000000000000000; InstrFrm = 3'b001; NXEnIn = 1'b1;
        tick();
        X = 64'hC008000000000000; InstrFrm = 3'b100; NXEnIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({InReady, OutValid, head} !== {2'b01, a}) begin
                bad++;
                $display("FAIL b2b_stall%0d: got %b %b %h want 0 1 %h", i, InReady, OutValid, head, a);
            end
            tick();
        end
        OutReady = 1'b1;
        tick();
        total++;
        if ({OutValid, head} !== {1'b1, b}) begin
            bad++;
            $display("FAIL b2b_second: got %h want %h", head, b);
        end
        tick();
        InValid = 1'b0;
        total++;
        if ({OutValid, head} !== {1'b1, c}) begin
            bad++;
            $display("FAIL b2b_third: got %h want %h", head, c);
        end
        tick();
        total++;
        if (OutValid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got %b want 0", OutValid);
        end
    endtask

    task automatic test_flush_reset();
        OutReady = 1'b0;
        issue(64'h3FF0000000000000, 2'b01, 3'b000, 3'b000, 1'b0);
        issue(64'h4000000000000000, 2'b01, 3'b000, 3'b000, 1'b0);
        total++;
        if ({OutValid, InReady} !== 2'b10) begin
            bad++;
            $display("FAIL flush_full: got %b want 10", {OutValid, InReady});
        end
        FlushE = 1'b1;
        issue(64'hC008000000000000, 2'b01, 3'b000, 3'b000, 1'b0);
        total++;
        if ({OutValid, InReady, IllegalOp} !== 3'b010) begin
            bad++;
            $display("FAIL flush_clear: got %b want 010", {OutValid, InReady, IllegalOp});
        end
        // Illegal and legal requests coinciding with a flush are both dropped
        issue(64'h3FF0000000000000, 2'b01, 3'b101, 3'b000, 1'b0);
        issue(64'h3FF0000000000000, 2'b01, 3'b000, 3'b000, 1'b0);
        total++;
        if ({OutValid, IllegalOp} !== 2'b00) begin
            bad++;
            $display("FAIL flush_suppress: got %b want 00", {OutValid, IllegalOp});
        end
        FlushE = 1'b0;
        issue(64'h3FF0000000000000, 2'b01, 3'b000, 3'b000, 1'b0);
        InValid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({OutValid, InReady} !== 2'b01) begin
            bad++;
            $display("FAIL async_reset: got %b want 01", {OutValid, InReady});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        InValid = 1'b0;
        OutReady = 1'b1;
        tick();
        tick();
        total++;
        if ({OutValid, IllegalOp} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset: got %b want 00", {OutValid, IllegalOp});
        end
    endtask

    task automatic test_random();
        item_t    q[$];
        logic     exp_ill;
        logic [2:0] rm;
        logic     ill;
        logic     acc;
        exp_ill = 1'b0;
        FlushE  = 1'b0;
        for (int c = 0; c < 500; c++) begin
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            FlushE   = ($urandom_range(0, 24) == 0);
            X        = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) X[63:32] = 32'hFFFF_FFFF;
            case ($urandom_range(0, 5))
                0: begin X[30:23] = 8'hFF; X[62:52] = 11'h7FF; end
                1: begin X[30:23] = 8'h00; X[62:52] = 11'h000; end
                default: ;
            endcase
            case ($urandom_range(0, 7))
                0, 1, 2: FmtIn = 2'b00;
                3, 4, 5: FmtIn = 2'b01;
                6:       FmtIn = 2'b10;
                default: FmtIn = 2'b11;
            endcase
            InstrFrm = 3'($urandom_range(0, 7));
            CsrFrm   = 3'($urandom_range(0, 7));
            NXEnIn   = 1'($urandom_range(0, 1));

            total++;
            if ({OutValid, InReady, IllegalOp} !== {q.size() != 0, q.size() < 2, exp_ill}) begin
                bad++;
                $display("FAIL rand_ctrl@%0d: got %b want %b", c, {OutValid, InReady, IllegalOp},
                         {q.size() != 0, q.size() < 2, exp_ill});
            end
            if (q.size() != 0) begin
                total++;
                if (head !== q[0]) begin
                    bad++;
                    $display("FAIL rand_head@%0d: got %h want %h", c, head, q[0]);
                end
            end

            rm  = (InstrFrm == 3'b111) ? CsrFrm : InstrFrm;
            ill = (rm > 3'd4) || (FmtIn == 2'b11) || (FmtIn == 2'b10);
            acc = InValid && (q.size() < 2);
            if (FlushE) begin
                q.delete();
                exp_ill = 1'b0;
            end else begin
                if (q.size() != 0 && OutReady) void'(q.pop_front());
                if (acc && !ill) q.push_back(model(X, FmtIn, rm, NXEnIn));
                exp_ill = acc && ill;
            end
            tick();
        end
        InValid = 1'b0;
        FlushE  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_double();
        test_single();
        test_nan();
        test_illegal();
        test_back_to_back();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fround_issue.md
Name: fround_issue

Overview:
Upstream issue/operand stage for the Zfa round-to-integer datapath (fround/froundnx).
- Accepts packed, NaN-boxed FP operands with a valid/ready handshake.
- Resolves the dynamic rounding mode and rejects illegal requests.
- Unpacks each operand into sign / widened exponent / U1.NF significand plus NaN classification.
- Buffers up to two requests in a skid buffer, then presents one registered request per cycle to the combinational rounder.

Parameters:
FLEN, 64, register width; packed operand width
NE, 11, widest-format exponent width
NF, 52, widest-format fraction width
BIAS, 1023, widest-format exponent bias
FMTBITS, 2, format field width
LOGFLEN, 6, width of the Nf field
HAS_H, 0, 1 = half precision legal (exponent 5, fraction 10, bias 15)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
FlushE  in  1  synchronous flush, clears buffered requests
InValid  in  1  request valid
InReady  out  1  stage can accept a request
X  in  FLEN  packed operand; narrower formats are NaN-boxed
FmtIn  in  FMTBITS  format: 00 single, 01 double, 10 half, 11 quad
InstrFrm  in  3  rm field from the instruction
CsrFrm  in  3  frm CSR value
NXEnIn  in  1  request is froundnx
OutValid  out  1  head entry valid
OutReady  in  1  downstream consumes head
Xs  out  1  sign
Xe  out  NE  exponent re-biased to BIAS
Xm  out  NF+1  significand, U1.NF, left-aligned
XNaN  out  1  operand is NaN
XSNaN  out  1  operand is signalling NaN
Fmt  out  FMTBITS  format of head entry
Frm  out  3  resolved rounding mode, 000..100 only
Nf  out  LOGFLEN  fraction bits of head format
ZfaFRoundNX  out  1  head is froundnx
IllegalOp  out  1  one-cycle pulse: an accepted request was rejected

Behaviour:
Reset (async, reset_n low):
- count=0, OutValid=0, InReady=1, IllegalOp=0.
- All payload registers 0.
- Reset mid-operation discards all entries; nothing is emitted afterwards.

Accept and rounding mode:
- A request is accepted when InValid & InReady.
- InReady = (count<2); it is a function of registered count only, with no combinational path from OutReady.
- Resolved rm: rm = (InstrFrm==111) ? CsrFrm : InstrFrm.

Illegal requests:
- A request is illegal if rm ∈ {101,110,111}, FmtIn==11, or FmtIn==10 with HAS_H=0.
- An illegal request is accepted but not enqueued; IllegalOp=1 in the following cycle.

Skid buffer:
- 2-entry FIFO with head at index rd; the outputs come from registers, i.e. the head entry.
- Enqueue latency is 1: a request accepted in cycle n with an empty buffer gives OutValid=1 in cycle n+1.
- Dequeue happens when OutValid & OutReady.
- count transitions: enqueue only +1, dequeue only −1, both: unchanged (legal at count=1; count=2 cannot enqueue).
- Head outputs stay stable while OutValid & ~OutReady.
- Pointers are 1 bit and wrap naturally.

Flush:
- FlushE sets count=0 and suppresses any same-cycle enqueue and IllegalOp.
- Flush has priority over accept and dequeue.
- InReady=1 in the next cycle.

Unpack (computed at enqueue):
- Double:
  - Xs=X[63], Xe=X[62:52], Xm={|Xe, X[51:0]}, Nf=52.
- Single:
  - If X[63:32] is not all ones, the operand is an unboxed canonical NaN: Xs=0, Xe=all 1, Xm={1,1,0…}, XNaN=1, XSNaN=0.
  - Otherwise e=X[30:23]. Xe = 0 if e==0; all 1 if e==FF; else e+896.
  - Xm={e!=0, X[22:0], 29'b0}, Nf=23.
- Half (HAS_H=1):
  - Box check on X[63:16]; exponent offset +1008.
  - Xm={e!=0, X[9:0], 42'b0}, Nf=10.
- Subnormals map to Xe=0 with hidden bit 0; the rounder treats them as |X|<1.
- NaN classification: format exponent all ones and fraction ≠0 gives XNaN. XSNaN = XNaN & fraction MSB==0 & boxed.
- Infinity passes through as Xe=all 1, fraction 0.

Decomposition:
- Shared package fround_pkg holds:
  - format encodings (FMT_S, FMT_D, FMT_H, FMT_Q);
  - per-format exponent width, fraction width, bias and re-bias offset;
  - Nf constants;
  - rounding-mode encodings (RNE, RZ, RDN, RUP, RMM, DYN);
  - an unpacked-operand struct (sign, exp, sig, nan, snan).
- One combinational sub-module, fround_unpack (X, Fmt → struct), instantiated on the enqueue path.
- The FIFO and control stay in fround_issue.

Test Plan:
1. Double 2.5 (0x4004000000000000), InstrFrm=000, OutReady=1 → cycle+1: OutValid=1, Xs=0, Xe=0x400, Xm=0x14000000000000, Nf=52, Frm=000.
2. Single −1.5 boxed (0xFFFFFFFFBFC00000), InstrFrm=111, CsrFrm=011 → Xs=1, Xe=0x3FF, Xm=0x18000000000000, Nf=23, Frm=011. The same operand as 0x00000000BFC00000 → XNaN=1, XSNaN=0, Xe=0x7FF.
3. Single sNaN 0xFFFFFFFF7F800001 → XNaN=1, XSNaN=1. Quiet NaN 0xFFFFFFFF7FC00000 → XSNaN=0.
4. InstrFrm=111, CsrFrm=101, InValid=1 → accepted, IllegalOp=1 next cycle, OutValid stays 0, count 0. Likewise FmtIn=11.
5. OutReady=0, three back-to-back requests A, B, C → A and B accepted, InReady=0 while C is held. With OutReady=1, emission order is A, B, C, and head values are stable throughout the stall.
6. Two entries buffered, FlushE=1 together with InValid=1 → next cycle OutValid=0, InReady=1, no IllegalOp. Then reset_n low mid-stream → OutValid=0 immediately (asynchronous), and no output after release.
